regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port A (ALU result) and port M (memory load result).
- Each requester has its own small FIFO. A round-robin arbiter drains one entry per cycle into registered WriteReg/DstReg/DstData outputs that drive the register file write port directly.
- A per-register pending mask is exported so the hazard/stall logic can see writes still in flight.

Parameters:
- QDEPTH, 2, entries per requester FIFO; power of two, ≥2.
- QAW, 1, FIFO pointer width = log2(QDEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- a_valid  input  1  ALU write request.
- a_ready  output  1  ALU FIFO can accept.
- a_reg  input  4  ALU destination register.
- a_data  input  16  ALU write data.
- m_valid  input  1  memory write request.
- m_ready  output  1  memory FIFO can accept.
- m_reg  input  4  memory destination register.
- m_data  input  16  memory write data.
- WriteReg  output  1  register file write enable.
- DstReg  output  4  register file write address.
- DstData  output  16  register file write data.
- pending  output  16  bit r high while any write to register r is queued or on the output stage.

Behaviour:
- Reset: FIFOs emptied; WriteReg=0; DstReg=0; DstData=0; pending=0; last_grant=M, so the first tie goes to A. Reset overrides any accept or grant in the same cycle, and in-flight entries are discarded.
- Accept: an entry is enqueued at an edge where x_valid && x_ready.
  - x_ready = (count_x < QDEPTH), computed from the registered count only. It stays 0 when the FIFO is full, even if that FIFO is dequeued in the same cycle.
  - x_valid while not ready is ignored; the entry is not stored.
- FIFO: per-requester circular buffer with wrapping read/write pointers and a count of 0..QDEPTH. Order within a requester is strictly preserved. Simultaneous enqueue and dequeue leaves the count unchanged.
- Arbitration, evaluated every cycle:
  - Only A non-empty: grant A.
  - Only M non-empty: grant M.
  - Both non-empty: grant the requester other than last_grant.
  - last_grant updates only on an actual grant.
  - Neither non-empty: no grant.
- Output stage, registered:
  - On a grant, the head entry is popped and WriteReg=1, DstReg=head.reg, DstData=head.data at the next edge.
  - With no grant, WriteReg=0, DstReg=0, DstData=0.
  - WriteReg is a single-cycle pulse per entry, with at most one write per cycle.
- Latency: an entry accepted into an empty FIFO at edge k with no competing head appears on WriteReg during the cycle after edge k+1.
- Throughput: one write per cycle sustained. Under contention from both requesters, A and M alternate.
- pending: combinational OR, over all valid FIFO entries and the output stage while WriteReg=1, of one-hot(reg).
  - Bit r clears in the cycle after the last write to r has been presented on the output.
  - Cross-requester writes to the same register commit in grant order. Ordering these is upstream's responsibility, using pending.
- Register 0 is handled like any other register unless WB_R0_DISCARD_EN is defined (see Optional Feature).

Optional Feature:
- Macro: WB_R0_DISCARD_EN.
- Defined:
  - Requests with reg==0 are still accepted (x_ready handshake unchanged) but are not enqueued. They never reach WriteReg and never set pending[0].
  - pending[0] is constant 0.
  - A discarded request consumes no FIFO slot.
- Undefined: register 0 requests are queued and written like any other register.

Test Plan:
- Reset, then a single request a_valid=1, a_reg=3, a_data=16'h1234 for one cycle:
  - WriteReg=1, DstReg=3, DstData=16'h1234 for exactly one cycle, two edges after acceptance.
  - pending[3] is high from the accept until the cycle after the write.
- Both requesters valid every cycle (A: R1..R4 = 16'hA001..16'hA004, M: R5..R8 = 16'hB001..16'hB004):
  - Writes alternate A,M,A,M… starting with A (R1,R5,R2,R6,…).
  - All 8 writes are seen; per-requester order is preserved.
- Fill the M FIFO (QDEPTH=2) with no drain possible due to A contention: m_ready=0 after two accepts. A third m_valid held high is accepted only after m_ready rises, and no data is lost or duplicated.
- Assert rst while both FIFOs hold entries and WriteReg=1: the next cycle shows WriteReg=0, pending=16'h0000, a_ready=m_ready=1, and no stale write ever appears afterwards.
- With WB_R0_DISCARD_EN defined, request a_reg=0, a_data=16'hFFFF followed by a_reg=2, a_data=16'h0002: no write to R0 occurs and pending[0] stays 0. R2 is written with 16'h0002 at minimum latency.
- Without WB_R0_DISCARD_EN, the same stimulus writes R0=16'hFFFF and then R2=16'h0002.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file's single write port.
// Optional: define WB_R0_DISCARD_EN to accept-and-drop writes to register 0.
module regfile_write_arbiter #(
   parameter int QDEPTH = 2,
   parameter int QAW    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [3:0]  a_reg,
   input  logic [15:0] a_data,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [3:0]  m_reg,
   input  logic [15:0] m_data,
   output logic        WriteReg,
   output logic [3:0]  DstReg,
   output logic [15:0] DstData,
   output logic [15:0] pending
);

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_M = 1'b1
   } grantE;

   localparam logic [QAW:0] QFULL = (QAW + 1)'(QDEPTH);

   logic [3:0]     aRegQ  [QDEPTH];
   logic [15:0]    aDataQ [QDEPTH];
   logic [QAW-1:0] aRdPtr, aWrPtr;
   logic [QAW:0]   aCount;

   logic [3:0]     mRegQ  [QDEPTH];
   logic [15:0]    mDataQ [QDEPTH];
   logic [QAW-1:0] mRdPtr, mWrPtr;
   logic [QAW:0]   mCount;

   grantE lastGrant;
   logic  aPush, mPush;
   logic  aNonEmpty, mNonEmpty;
   logic  grantA, grantM;

   // Ready depends only on the registered count, so a full FIFO stays closed
   // even in a cycle where it is being drained.
   assign a_ready = (aCount < QFULL);
   assign m_ready = (mCount < QFULL);

`ifdef WB_R0_DISCARD_EN
   assign aPush = a_valid && a_ready && (a_reg != 4'd0);
   assign mPush = m_valid && m_ready && (m_reg != 4'd0);
`else
   assign aPush = a_valid && a_ready;
   assign mPush = m_valid && m_ready;
`endif

   assign aNonEmpty = (aCount != '0);
   assign mNonEmpty = (mCount != '0);
   assign grantA    = aNonEmpty && (!mNonEmpty || (lastGrant == GRANT_M));
   assign grantM    = mNonEmpty && (!aNonEmpty || (lastGrant == GRANT_A));

   // NOTE: FIFO storage has no reset; count and pointers alone define which slots are live.
   always_ff @(posedge clk) begin
      if (aPush) begin
         aRegQ[aWrPtr]  <= a_reg;
         aDataQ[aWrPtr] <= a_data;
      end
      if (mPush) begin
         mRegQ[mWrPtr]  <= m_reg;
         mDataQ[mWrPtr] <= m_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every block sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         aRdPtr <= '0;
         aWrPtr <= '0;
         aCount <= '0;
      end else begin
         if (aPush)  aWrPtr <= aWrPtr + 1'b1;
         if (grantA) aRdPtr <= aRdPtr + 1'b1;
         case ({aPush, grantA})
            2'b10:   aCount <= aCount + 1'b1;
            2'b01:   aCount <= aCount - 1'b1;
            default: aCount <= aCount;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mRdPtr <= '0;
         mWrPtr <= '0;
         mCount <= '0;
      end else begin
         if (mPush)  mWrPtr <= mWrPtr + 1'b1;
         if (grantM) mRdPtr <= mRdPtr + 1'b1;
         case ({mPush, grantM})
            2'b10:   mCount <= mCount + 1'b1;
            2'b01:   mCount <= mCount - 1'b1;
            default: mCount <= mCount;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         WriteReg  <= 1'b0;
         DstReg    <= '0;
         DstData   <= '0;
         lastGrant <= GRANT_M;
      end else if (grantA) begin
         WriteReg  <= 1'b1;
         DstReg    <= aRegQ[aRdPtr];
         DstData   <= aDataQ[aRdPtr];
         lastGrant <= GRANT_A;
      end else if (grantM) begin
         WriteReg  <= 1'b1;
         DstReg    <= mRegQ[mRdPtr];
         DstData   <= mDataQ[mRdPtr];
         lastGrant <= GRANT_M;
      end else begin
         WriteReg  <= 1'b0;
         DstReg    <= '0;
         DstData   <= '0;
      end
   end

   // A slot is live when its distance from the read pointer is below the count.
   function automatic logic slotLive(input logic [QAW-1:0] rdPtr,
                                     input logic [QAW:0]   count,
                                     input int             idx);
      logic [QAW-1:0] offset;
      offset = QAW'(idx) - rdPtr;
      return ({1'b0, offset} < count);
   endfunction

   // NOTE: defaulting pending first keeps this block purely combinational (no latch).
   always_comb begin
      pending = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (slotLive(aRdPtr, aCount, i)) pending[aRegQ[i]] = 1'b1;
         if (slotLive(mRdPtr, mCount, i)) pending[mRegQ[i]] = 1'b1;
      end
      if (WriteReg) pending[DstReg] = 1'b1;
`ifdef WB_R0_DISCARD_EN
      pending[0] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued by the
// stimulus, a negedge monitor pops and compares each WriteReg pulse.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, m_valid;
   logic        a_ready, m_ready;
   logic [3:0]  a_reg, m_reg;
   logic [15:0] a_data, m_data;
   logic        WriteReg;
   logic [3:0]  DstReg;
   logic [15:0] DstData;
   logic [15:0] pending;

   typedef struct packed {
      logic [3:0]  r;
      logic [15:0] d;
   } wrT;

   wrT expQ[$];
   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.QDEPTH(2), .QAW(1)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
      .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      wrT e;
      if (WriteReg === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got reg=%0d data=%h, expected no write", DstReg, DstData);
         end else begin
            e = expQ.pop_front();
            check("write_reg", {28'd0, DstReg}, {28'd0, e.r});
            check("write_data", {16'd0, DstData}, {16'd0, e.d});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_valid = 1'b0;
      m_valid = 1'b0;
      step();
      rst = 1'b0;
      expQ.delete();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20; i++) begin
         if (expQ.size() == 0) break;
         step();
      end
      check(name, expQ.size(), 0);
   endtask

   task automatic driveA(input logic v, input logic [3:0] r, input logic [15:0] d);
      a_valid = v; a_reg = r; a_data = d;
   endtask

   task automatic driveM(input logic v, input logic [3:0] r, input logic [15:0] d);
      m_valid = v; m_reg = r; m_data = d;
   endtask

   logic [3:0]  aRegs [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
   logic [15:0] aDats [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
   logic [3:0]  mRegs [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
   logic [15:0] mDats [4] = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};

   initial begin
      int ai, mi;
      logic aAcc, mAcc;
      rst = 1'b1;
      driveA(1'b0, 4'd0, 16'h0);
      driveM(1'b0, 4'd0, 16'h0);
      step();
      step();
      check("rst_writereg", WriteReg, 0);
      check("rst_dstreg", DstReg, 0);
      check("rst_dstdata", DstData, 0);
      check("rst_pending", pending, 0);
      check("rst_a_ready", a_ready, 1);
      check("rst_m_ready", m_ready, 1);
      rst = 1'b0;

      // Single request: write appears two edges after acceptance, for one cycle.
      driveA(1'b1, 4'd3, 16'h1234);
      expQ.push_back('{4'd3, 16'h1234});
      step();
      driveA(1'b0, 4'd0, 16'h0);
      check("single_pend_queued", pending, 16'h0008);
      check("single_no_early_write", WriteReg, 0);
      step();
      check("single_write", WriteReg, 1);
      check("single_pend_output", pending, 16'h0008);
      step();
      check("single_write_ends", WriteReg, 0);
      check("single_pend_clear", pending, 0);
      drain("single_drain");

      // Full contention: strict A/M alternation starting with A.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         expQ.push_back('{aRegs[i], aDats[i]});
         expQ.push_back('{mRegs[i], mDats[i]});
      end
      ai = 0;
      mi = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (ai == 4 && mi == 4 && expQ.size() == 0) break;
         if (ai < 4) driveA(1'b1, aRegs[ai], aDats[ai]); else driveA(1'b0, 4'd0, 16'h0);
         if (mi < 4) driveM(1'b1, mRegs[mi], mDats[mi]); else driveM(1'b0, 4'd0, 16'h0);
         aAcc = a_valid && a_ready;
         mAcc = m_valid && m_ready;
         step();
         if (aAcc) ai++;
         if (mAcc) mi++;
      end
      driveA(1'b0, 4'd0, 16'h0);
      driveM(1'b0, 4'd0, 16'h0);
      check("contend_a_sent", ai, 4);
      check("contend_m_sent", mi, 4);
      check("contend_drain", expQ.size(), 0);

      // M FIFO fills; third M request waits for m_ready.
      do_reset();
      expQ.push_back('{4'd9,  16'hC001});
      expQ.push_back('{4'd10, 16'hD001});
      expQ.push_back('{4'd11, 16'hC002});
      expQ.push_back('{4'd12, 16'hD002});
      expQ.push_back('{4'd13, 16'hD003});
      driveA(1'b1, 4'd9, 16'hC001);
      driveM(1'b1, 4'd10, 16'hD001);
      step();
      driveA(1'b1, 4'd11, 16'hC002);
      driveM(1'b1, 4'd12, 16'hD002);
      step();
      check("full_m_not_ready", m_ready, 0);
      check("full_a_ready", a_ready, 1);
      driveA(1'b0, 4'd0, 16'h0);
      driveM(1'b1, 4'd13, 16'hD003);
      step();
      check("full_m_ready_again", m_ready, 1);
      step();
      driveM(1'b0, 4'd0, 16'h0);
      drain("full_drain");

      // Reset while both FIFOs hold entries and a write is on the output.
      do_reset();
      expQ.push_back('{4'd1, 16'h1111});
      driveA(1'b1, 4'd1, 16'h1111);
      driveM(1'b1, 4'd3, 16'h3333);
      step();
      driveA(1'b1, 4'd2, 16'h2222);
      driveM(1'b1, 4'd4, 16'h4444);
      step();
      check("midrst_write_live", WriteReg, 1);
      check("midrst_pending_live", pending, 16'h001E);
      rst = 1'b1;
      driveA(1'b0, 4'd0, 16'h0);
      driveM(1'b0, 4'd0, 16'h0);
      step();
      check("midrst_writereg", WriteReg, 0);
      check("midrst_dstreg", DstReg, 0);
      check("midrst_dstdata", DstData, 0);
      check("midrst_pending", pending, 0);
      check("midrst_a_ready", a_ready, 1);
      check("midrst_m_ready", m_ready, 1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("midrst_no_stale", expQ.size(), 0);

      // Register 0 request followed by register 2.
`ifndef WB_R0_DISCARD_EN
      expQ.push_back('{4'd0, 16'hFFFF});
`endif
      expQ.push_back('{4'd2, 16'h0002});
      driveA(1'b1, 4'd0, 16'hFFFF);
      step();
`ifdef WB_R0_DISCARD_EN
      check("r0_pend_after_accept", pending[0], 0);
`else
      check("r0_pend_after_accept", pending[0], 1);
`endif
      driveA(1'b1, 4'd2, 16'h0002);
      step();
      driveA(1'b0, 4'd0, 16'h0);
`ifdef WB_R0_DISCARD_EN
      check("r0_no_write", WriteReg, 0);
      check("r0_pend_zero", pending[0], 0);
`else
      check("r0_write", WriteReg, 1);
      check("r0_write_reg", DstReg, 0);
`endif
      step();
      check("r2_write", WriteReg, 1);
      check("r2_write_reg", DstReg, 2);
      check("r2_write_data", DstData, 16'h0002);
      step();
      check("r0r2_idle", pending, 0);
      drain("r0r2_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
